// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants for the sprite line scheduler: entry field layout,
// default geometry and the scan FSM state encoding.
package sprite_line_scheduler_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int SLOT_NUM_DEF   = 8;
    localparam int SPRITE_H_DEF   = 16;
    localparam int POS_W_DEF      = 10;

    localparam int X_LSB    = 0;
    localparam int X_MSB    = 7;
    localparam int Y_LSB    = 8;
    localparam int Y_MSB    = 15;
    localparam int TILE_LSB = 16;
    localparam int TILE_MSB = 23;
    localparam int ATTR_LSB = 24;
    localparam int ATTR_MSB = 30;
    localparam int EN_BIT   = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Sprite RAM line-evaluation read port: strobe and index out, entry data
// back one cycle later.
interface sprite_line_scheduler_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;

    modport master (
        output ram_rd_en,
        output ram_addr,
        input  ram_rdata
    );

    modport slave (
        input  ram_rd_en,
        input  ram_addr,
        output ram_rdata
    );
endinterface

// File: rtl/sprite_line_scheduler_y_hit.sv
// Vertical coverage test of one sprite entry against the target line.
module sprite_y_hit
    import sprite_line_scheduler_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  logic [Y_MSB-Y_LSB:0] y_pos,
    input  logic                 en,
    input  logic [POS_W-1:0]     line_y,
    output logic                 hit
);
    logic signed [POS_W:0] d;

    // One extra bit so a sprite starting below the line shows up as a borrow.
    always_comb begin
        d   = $signed({1'b0, line_y}) - $signed({{(POS_W-7){1'b0}}, y_pos});
        hit = en && !d[POS_W] && (d[POS_W-1:0] < (POS_W)'(SPRITE_H));
    end
endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluation: publishes the gathered slot set on each
// line_start, then scans sprite RAM for up to SLOT_NUM sprites on the next line.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int SLOT_NUM   = SLOT_NUM_DEF,
    parameter int SPRITE_H   = SPRITE_H_DEF,
    parameter int POS_W      = POS_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_start,
    input  logic [POS_W-1:0]       next_line_y,
    sprite_line_scheduler_if.master ram,
    output logic [SLOT_NUM*32-1:0] slot_data,
    output logic [SLOT_NUM-1:0]    slot_valid,
    output logic                   overflow,
    output logic                   late,
    input  logic                   late_clr,
    output logic                   busy
);
    localparam int CNT_W = $clog2(SLOT_NUM + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [POS_W-1:0]        line_y_q;
    logic [CNT_W-1:0]        hit_cnt;
    logic [SLOT_NUM*32-1:0]  back_data;
    logic [SLOT_NUM-1:0]     back_valid;
    logic                    back_ovf;
    logic                    vld_p1;
    logic                    hit_p1;
    logic                    stop;
    logic                    ls_mask;
    logic                    ls;

    // A pulse straddling reset release is not taken on the first edge.
    assign ls = line_start && !ls_mask;

    sprite_y_hit #(
        .POS_W    (POS_W),
        .SPRITE_H (SPRITE_H)
    ) u_y_hit (
        .y_pos  (ram.ram_rdata[Y_MSB:Y_LSB]),
        .en     (ram.ram_rdata[EN_BIT]),
        .line_y (line_y_q),
        .hit    (hit_p1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stop       = vld_p1 && hit_p1 && (hit_cnt == CNT_W'(SLOT_NUM));
        unique case (state)
            IDLE:    if (ls) state_next = SCAN;
            SCAN: begin
                if (ls)                   state_next = SCAN;
                else if (stop)            state_next = IDLE;
                else if (idx == LAST_IDX) state_next = DRAIN;
            end
            DRAIN:   state_next = ls ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
        ram.ram_rd_en = (state == SCAN);
        ram.ram_addr  = idx;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_mask    <= 1'b1;
            vld_p1     <= 1'b0;
            idx        <= '0;
            line_y_q   <= '0;
            hit_cnt    <= '0;
            back_data  <= '0;
            back_valid <= '0;
            back_ovf   <= 1'b0;
            slot_data  <= '0;
            slot_valid <= '0;
            overflow   <= 1'b0;
            late       <= 1'b0;
        end else begin
            ls_mask <= 1'b0;
            // p1: read data returns; reads issued on a restart or stop edge are stale
            vld_p1  <= ram.ram_rd_en && !ls && !stop;
            if (ls) begin
                slot_data  <= back_data;
                slot_valid <= back_valid;
                overflow   <= back_ovf;
                back_valid <= '0;
                back_ovf   <= 1'b0;
                hit_cnt    <= '0;
                idx        <= '0;
                line_y_q   <= next_line_y;
            end else begin
                if (state == SCAN) idx <= idx + 1'b1;
                if (vld_p1 && hit_p1) begin
                    if (stop) begin
                        back_ovf <= 1'b1;
                    end else begin
                        for (int k = 0; k < SLOT_NUM; k++) begin
                            if (hit_cnt == CNT_W'(k)) begin
                                back_data[k*32 +: 32] <= ram.ram_rdata;
                                back_valid[k]         <= 1'b1;
                            end
                        end
                        hit_cnt <= hit_cnt + 1'b1;
                    end
                end
            end
            if (ls && busy)    late <= 1'b1;
            else if (late_clr) late <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench: each line_start pushes the slot set the scan should find,
// the next line_start publishes it and it is popped and compared.
module tb_sprite_line_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [9:0]  next_line_y;
    logic [255:0] slot_data;
    logic [7:0]  slot_valid;
    logic        overflow;
    logic        late;
    logic        late_clr;
    logic        busy;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [7:0]   valid;
        logic         ovf;
        logic [255:0] data;
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sprite_line_scheduler_if #(.ADDR_WIDTH(6)) ram_bus ();

    always @(posedge clk)
        if (ram_bus.ram_rd_en) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];

    sprite_line_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .line_start  (line_start),
        .next_line_y (next_line_y),
        .ram         (ram_bus),
        .slot_data   (slot_data),
        .slot_valid  (slot_valid),
        .overflow    (overflow),
        .late        (late),
        .late_clr    (late_clr),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [9:0] y, input int limit);
        exp_t e;
        int   n;
        int   d;
        e = '0;
        n = 0;
        for (int i = 0; i < limit; i++) begin
            d = int'(y) - int'(mem[i][15:8]);
            if (mem[i][31] && d >= 0 && d < 16) begin
                if (n < 8) begin
                    e.valid[n]         = 1'b1;
                    e.data[n*32 +: 32] = mem[i];
                    n++;
                end else begin
                    e.ovf = 1'b1;
                    break;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] entry(input logic en, input logic [7:0] y, input logic [7:0] tag);
        return {en, 7'h2A, tag, y, 8'h11 ^ tag};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = entry(1'b0, 8'hF0, 8'(i));
    endtask

    task automatic pulse_line(input logic [9:0] y);
        exp_t e;
        @(negedge clk);
        line_start  = 1'b1;
        next_line_y = y;
        @(negedge clk);
        line_start = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("slot_valid", 64'(slot_valid), 64'(e.valid));
            check("overflow", 64'(overflow), 64'(e.ovf));
            for (int k = 0; k < 8; k++)
                if (e.valid[k]) check($sformatf("slot%0d", k), 64'(slot_data[k*32 +: 32]), 64'(e.data[k*32 +: 32]));
        end
        sb.push_back(model(y, 64));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("busy_timeout", 64'd200, 64'd0);
    endtask

    task automatic load_a();
        clear_mem();
        mem[3]  = entry(1'b1, 8'd20, 8'h03);
        mem[10] = entry(1'b1, 8'd20, 8'h0A);
        mem[40] = entry(1'b1, 8'd20, 8'h28);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; line_start = 1'b0; late_clr = 1'b0; next_line_y = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(slot_valid), 64'd0);
        check("rst_data", 64'(slot_data[63:0]), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_late", 64'(late), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(ram_bus.ram_rd_en), 64'd0);
        check("rst_addr", 64'(ram_bus.ram_addr), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back('0);

        // three sprites at Y=20 targeted by line 25
        load_a();
        pulse_line(10'd25);
        wait_idle(n);
        check("busy_full", 64'(n), 64'd65);
        pulse_line(10'd25);
        wait_idle(n);

        // d=15 hits, d=-1 misses
        clear_mem();
        mem[5] = entry(1'b1, 8'd20, 8'h05);
        mem[6] = entry(1'b1, 8'd36, 8'h06);
        pulse_line(10'd35);
        wait_idle(n);

        // d=16 misses
        clear_mem();
        mem[5] = entry(1'b1, 8'd19, 8'h05);
        pulse_line(10'd35);
        wait_idle(n);

        // ten hits: early stop on the ninth
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = entry(1'b1, 8'd0, 8'(8'h40 + i));
        pulse_line(10'd5);
        wait_idle(n);
        check("busy_ovf", 64'(n), 64'd10);

        // disabled sprite on the line
        clear_mem();
        mem[7] = entry(1'b0, 8'd0, 8'h07);
        pulse_line(10'd5);
        wait_idle(n);

        // line_start 30 cycles into a scan
        load_a();
        pulse_line(10'd25);
        repeat (28) @(negedge clk);
        void'(sb.pop_back());
        sb.push_back(model(10'd25, 28));
        pulse_line(10'd25);
        check("late_set", 64'(late), 64'd1);
        check("restart_addr", 64'(ram_bus.ram_addr), 64'd0);
        check("restart_rd_en", 64'(ram_bus.ram_rd_en), 64'd1);
        wait_idle(n);
        check("busy_restart", 64'(n), 64'd65);
        check("late_hold", 64'(late), 64'd1);
        @(negedge clk);
        late_clr = 1'b1;
        @(negedge clk);
        late_clr = 1'b0;
        check("late_clr", 64'(late), 64'd0);

        // reset in the middle of a scan
        pulse_line(10'd25);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(slot_valid), 64'd0);
        check("mid_rst_data", 64'(slot_data[63:0]), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rd_en", 64'(ram_bus.ram_rd_en), 64'd0);
        check("mid_rst_addr", 64'(ram_bus.ram_addr), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        sb.delete();
        sb.push_back('0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_line(10'd25);
        wait_idle(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluation controller for the PPU.
- On each line-start pulse it publishes the previously gathered slot set to the eight tile-draw slots, then scans all sprite RAM entries through the RAM read port. It selects up to 8 sprites whose vertical extent covers the next line into a back buffer.
- Sits between the sprite RAM's line-evaluation read port and the eight tile-draw instances, in the 100 MHz compute domain.

Parameters:
- ADDR_WIDTH, 6, sprite RAM index width; SPRITE_NUM = 2**ADDR_WIDTH.
- SLOT_NUM, 8, number of tile-draw slots.
- SPRITE_H, 16, sprite height in lines.
- POS_W, 10, width of line coordinate (matches VGA_POSXY_BIT).

Ports:
- clk  in  1  compute clock (100 MHz domain).
- rst  in  1  asynchronous reset, active-high.
- line_start  in  1  one-cycle pulse, already synchronised into clk, once per scanline.
- next_line_y  in  POS_W  game-window line that the scan targets; sampled on line_start.
- ram_rd_en  out  1  read strobe to sprite RAM.
- ram_addr  out  ADDR_WIDTH  sprite index being read.
- ram_rdata  in  32  entry data, valid exactly 1 cycle after ram_rd_en.
- slot_data  out  SLOT_NUM*32  front-buffer entries; slot k at [32k+31:32k].
- slot_valid  out  SLOT_NUM  front-buffer valid mask, contiguous from bit 0.
- overflow  out  1  more than SLOT_NUM sprites hit the published line.
- late  out  1  sticky: a line_start arrived before the scan finished.
- late_clr  in  1  clears late.
- busy  out  1  high while a scan is in progress.

Behaviour:
- Entry format:
  - [7:0] X, [15:8] Y, [23:16] tile index, [30:24] attributes, [31] enable.
  - Slot data is passed through unmodified.
- Hit rule:
  - enable==1 and d = next_line_y_q - {0,Y} satisfies 0 <= d < SPRITE_H.
  - Subtract at POS_W+1 bits; borrow (MSB set) means no hit.
- Reset values: slot_data=0, slot_valid=0, overflow=0, late=0, busy=0, ram_rd_en=0, ram_addr=0. State=IDLE, back buffer and counters cleared. Reset mid-scan discards everything.
- States:
  - IDLE: on line_start, swap and go to SCAN.
  - SCAN: each cycle assert ram_rd_en with ram_addr=idx and increment idx. The compare stage evaluates the ram_rdata of idx-1 (1-cycle pipeline). After the last address is issued, go to DRAIN.
  - DRAIN: evaluate the final entry, then go to IDLE.
  - Early stop: when the (SLOT_NUM+1)th hit is detected, set back_ovf, drop ram_rd_en, and go to IDLE. The in-flight read is ignored.
- Swap on line_start (same edge):
  - slot_data <= back_data, slot_valid <= back_valid, overflow <= back_ovf.
  - Then clear back_valid, back_ovf, hit count and idx; latch next_line_y.
- Slot order: hits are written in increasing sprite index; slot k holds the k-th hit.
- Latency: full scan with ≤8 hits = SPRITE_NUM+1 cycles after line_start (65 at default). busy is high for exactly those cycles.
- line_start while busy:
  - Swap the partial back buffer (entries found so far), set late, and restart the scan from index 0.
  - If late_clr coincides with a late set, the set wins.
- late_clr while not busy clears late the next cycle.
- line_start is ignored for one cycle after reset deassertion only if it overlaps rst; no other masking.
- No combinational path from ram_rdata to any output.

Decomposition:
- Shared define/package holds: entry field offsets (X/Y/TILE/ATTR/EN bit positions), SPRITE_H, SLOT_NUM, POS_W, and the state encodings IDLE/SCAN/DRAIN.
- One natural sub-module: sprite_y_hit (combinational compare of entry vs line, returns hit). Everything else stays in the top FSM.

Test Plan:
- Three enabled sprites at Y=20 (idx 3, 10, 40), line_start with next_line_y=25, then a second line_start → slot_valid=8'b00000111, slots hold entries 3, 10, 40 in order; overflow=0; busy high for 65 cycles.
- Boundaries at next_line_y=35: sprites Y=20 (d=15) and Y=36 (d=-1) → only Y=20 hits; repeat with Y=19 (d=16) → no hit.
- Ten enabled sprites all Y=0, next_line_y=5 → after the swap, slot_valid=8'hFF, slots hold the first 8 indices, overflow=1, busy drops after the 9th hit.
- Entry with enable=0 and Y matching → not selected; slot_valid=0.
- Second line_start 30 cycles into a scan → partial set published, late=1, scan restarts at addr 0; pulse late_clr → late=0.
- rst asserted mid-SCAN → all outputs return to reset values asynchronously; the next line_start publishes empty slots (slot_valid=0).
